// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver: recovers start/data/[parity]/stop frames using the baud generator tick.
// Optional parity bit is enabled by defining UART_RX_PARITY_EN (PARITY_ODD then selects odd/even).
module uart_rx_oversampled #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
`ifdef UART_RX_PARITY_EN
  , parameter int unsigned PARITY_ODD = 0
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 BCLK,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 rx_s;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 valid_d, ferr_d, perr_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
`endif

  // Metastability synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end
  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = rx_data;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    if (BCLK) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_d = S_START;
            tick_d  = '0;
          end
        end
        S_START: begin
          // Re-check mid start bit so short glitches fall back to idle silently
          if (tick_q == TW'(OVERSAMPLE/2 - 1)) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = rx_s ? S_IDLE : S_DATA;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_DATA: begin
          if (tick_q == TW'(OVERSAMPLE - 1)) begin
            tick_d  = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_q == BW'(DATA_BITS - 1)) begin
              bit_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick_q == TW'(OVERSAMPLE - 1)) begin
            tick_d    = '0;
            par_bad_d = rx_s ^ (^shift_q) ^ 1'(PARITY_ODD);
            state_d   = S_STOP;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
`endif
        S_STOP: begin
          if (tick_q == TW'(OVERSAMPLE - 1)) begin
            tick_d = '0;
            if (rx_s) begin
              data_d  = shift_q;
              valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
              perr_d  = par_bad_q;
`endif
              state_d = S_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_BREAK: begin
          // Hold off until the line returns high so a stuck-low line cannot retrigger
          if (rx_s) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
    end else begin
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      rx_data    <= data_d;
      rx_valid   <= valid_d;
      frame_err  <= ferr_d;
      parity_err <= perr_d;
      busy       <= (state_d != S_IDLE);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) par_bad_q <= 1'b0;
    else       par_bad_q <= par_bad_d;
  end
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled: BCLK every 4 clks, 16x oversample, 8 data bits.
module tb_uart_rx_oversampled;

  localparam int unsigned BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       BCLK;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  typedef struct packed {
    logic       v;
    logic       fe;
    logic       pe;
    logic [7:0] d;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  uart_rx_oversampled dut (
    .clk       (clk),
    .reset     (reset),
    .BCLK      (BCLK),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    BCLK = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 BCLK = 1'b1;
      @(posedge clk);
      #1 BCLK = 1'b0;
    end
  end

  // Monitor: every strobe cycle must match the head of the expected queue
  always @(negedge clk) begin
    ev_t act, e;
    if (!reset && (rx_valid || frame_err || parity_err)) begin
      act = {rx_valid, frame_err, parity_err, rx_data};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: got v=%0b fe=%0b pe=%0b data=%h, required no strobe",
                 act.v, act.fe, act.pe, act.d);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_err++;
          $display("FAIL strobe_event: got v=%0b fe=%0b pe=%0b data=%h, required v=%0b fe=%0b pe=%0b data=%h",
                   act.v, act.fe, act.pe, act.d, e.v, e.fe, e.pe, e.d);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic send_bit(input logic b);
    #1 rx = b;
    repeat (BIT_CLKS) @(posedge clk);
  endtask

  task automatic send_data(input logic [7:0] d);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par);
    send_data(d);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`endif
    send_bit(1'b1);
  endtask

  task automatic expect_ok(input logic [7:0] d, input logic pe);
    exp_q.push_back({1'b1, 1'b0, pe, d});
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    #2 check("reset_outputs", 32'({rx_data, busy, rx_valid, frame_err, parity_err}), 32'h0);
    repeat (20) @(posedge clk);

    // Single frame
    expect_ok(8'hA5, 1'b0);
    send_frame(8'hA5, ^8'hA5);
    #2 check("busy_after_a5", 32'(busy), 32'd0);
    check("data_after_a5", 32'(rx_data), 32'hA5);

    // Back-to-back frames, no idle gap
    expect_ok(8'h00, 1'b0);
    expect_ok(8'hFF, 1'b0);
    send_frame(8'h00, 1'b0);
    send_frame(8'hFF, 1'b0);
    #2 check("data_after_ff", 32'(rx_data), 32'hFF);
    send_bit(1'b1);

    // Start-bit glitch of 5 ticks
    #1 rx = 1'b0;
    repeat (12) @(posedge clk);
    #2 check("busy_in_glitch", 32'(busy), 32'd1);
    repeat (8) @(posedge clk);
    #1 rx = 1'b1;
    repeat (3 * BIT_CLKS) @(posedge clk);
    #2 check("busy_after_glitch", 32'(busy), 32'd0);

    // Framing error with long break, then a clean frame
    exp_q.push_back({1'b0, 1'b1, 1'b0, 8'hFF});
    send_data(8'h3C);
`ifdef UART_RX_PARITY_EN
    send_bit(^8'h3C);
`endif
    #1 rx = 1'b0;
    repeat (40 * 4) @(posedge clk);
    #2 check("busy_in_break", 32'(busy), 32'd1);
    check("data_held_ferr", 32'(rx_data), 32'hFF);
    send_bit(1'b1);
    send_bit(1'b1);
    #2 check("busy_after_break", 32'(busy), 32'd0);
    expect_ok(8'h81, 1'b0);
    send_frame(8'h81, ^8'h81);
    #2 check("data_after_81", 32'(rx_data), 32'h81);
    send_bit(1'b1);

    // Reset mid-DATA aborts the frame
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'(8'h55 >> i));
    #1 rx = 1'b1;
    repeat (20) @(posedge clk);
    #2 check("busy_mid_data", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("reset_mid_frame", 32'({rx_data, busy, rx_valid, frame_err, parity_err}), 32'h0);
    repeat (4 * BIT_CLKS) @(posedge clk);
    check("busy_after_reset", 32'(busy), 32'd0);
    expect_ok(8'h12, 1'b0);
    send_frame(8'h12, ^8'h12);
    #2 check("data_after_12", 32'(rx_data), 32'h12);
    send_bit(1'b1);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so the correct parity bit is 1
    expect_ok(8'h07, 1'b0);
    send_frame(8'h07, 1'b1);
    send_bit(1'b1);
    expect_ok(8'h07, 1'b1);
    send_frame(8'h07, 1'b0);
    send_bit(1'b1);
`endif

    repeat (2 * BIT_CLKS) @(posedge clk);
    #2 check("pending_expected", 32'(exp_q.size()), 32'd0);
    check("busy_final", 32'(busy), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
